decode_uop_sequencer: RTL
=========================

Name: decode_uop_sequencer

Overview:
- Sits between fetch alignment and rename, wrapped around the combinational instruction field decoder.
- Holds one aligned instruction in a register and presents it to the decoder.
- Uses the decoder's unknown/complex flags to emit the instruction downstream as one micro-op, or cracks it into a fixed sequence of micro-ops (AMO read-modify-write).
- Provides valid/ready flow control on both sides and a pipeline flush.

Parameters:
PC_WIDTH, 64, width of instruction address carried with each uop
CRACK_UOPS, 3, number of uops a complex instruction expands to (min 2, max 4)
SEQ_WIDTH, 2, width of uop sequence index; must hold CRACK_UOPS-1

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_flush  in  1  discard held instruction and any in-progress crack
i_valid  in  1  fetch offers an instruction
i_instr  in  32  aligned instruction word
i_pc  in  PC_WIDTH  instruction address
o_ready  out  1  block accepts i_instr this cycle
o_dec_instr  out  32  held instruction word, driven to decoder
i_dec_unknown  in  1  decoder: held instruction is illegal/unknown
i_dec_complex  in  1  decoder: held instruction needs cracking
o_uop_valid  out  1  uop available to rename
i_uop_ready  in  1  rename accepts uop
o_uop_instr  out  32  instruction word of current uop
o_uop_pc  out  PC_WIDTH  address of current uop
o_uop_seq  out  SEQ_WIDTH  uop index within instruction, 0-based
o_uop_last  out  1  final uop of this instruction
o_uop_illegal  out  1  uop carries illegal-instruction exception

Behaviour:
- Clock and reset: one clock, i_clk. Reset i_rst_n is asynchronous, active-low.
- Reset values: state EMPTY, seq counter 0, held instr/pc 0, o_uop_valid 0, o_uop_last 0, o_uop_illegal 0, o_uop_seq 0, o_dec_instr 0. o_ready is 1 while i_flush is 0.
- States:
  - EMPTY: no instruction held.
  - SINGLE: held instruction emits one uop.
  - CRACK: held instruction emits CRACK_UOPS uops.
- Class decision: state after a load is a single registered FULL flag. The decoder flags are sampled combinationally each cycle from o_dec_instr = held instr. SINGLE and CRACK are derived from the flags, with illegal taking precedence: unknown -> SINGLE with illegal set; else complex -> CRACK; else SINGLE.
- o_uop_valid = FULL & ~i_flush.
- o_uop_illegal = FULL & i_dec_unknown.
- o_uop_last:
  - SINGLE: 1.
  - CRACK: 1 when seq == CRACK_UOPS-1.
- Handshake: a uop transfers when o_uop_valid & i_uop_ready.
  - Non-last uop transfer: seq increments; held instr/pc unchanged.
  - Last uop transfer: seq resets to 0.
- o_ready = ~i_flush & (~FULL | (o_uop_valid & i_uop_ready & o_uop_last)). This allows back-to-back accept on the cycle the last uop leaves, giving 1 instruction/cycle for simple instructions.
- Load: when i_valid & o_ready, capture i_instr/i_pc and set FULL. Otherwise, a last-uop transfer clears FULL.
- Latency: instruction accepted at cycle N produces its first uop valid at N+1.
- Stability: while o_uop_valid & ~i_uop_ready, all uop outputs stay stable.
- Flush:
  - Same cycle: o_uop_valid=0 and o_ready=0; input is not accepted.
  - Next edge: FULL=0, seq=0.
  - Flush mid-crack abandons the remaining uops.
  - Flush has priority over every handshake in the same cycle.
- Decoder flags are ignored while EMPTY.
- A class change mid-crack is impossible, because the held instr is frozen.
- Reset asserted mid-crack forces EMPTY immediately; no partial uop is emitted after reset release.
- seq never exceeds CRACK_UOPS-1. The SINGLE class always reports seq 0.

Test Plan:
- Simple ADDI 0x00500093 at pc 0x1000, rename ready -> one uop at next cycle: seq 0, last 1, illegal 0, pc 0x1000; o_ready stays 1.
- AMOADD.W 0x00B5202F with dec_complex=1, rename ready -> 3 consecutive uops with seq 0,1,2 and last only on seq 2. o_ready is 0 for 2 cycles and 1 on the seq-2 cycle; a queued ADDI is accepted then.
- Word 0x00000000 with dec_unknown=1 and dec_complex=1 -> single uop: illegal 1, last 1, seq 0; no crack.
- Backpressure: i_uop_ready low 4 cycles during seq 1 of an AMO -> outputs stable (seq 1, same pc/instr), o_ready 0; resumes with seq 2 after ready rises.
- Flush in seq-1 cycle of an AMO with i_valid high -> o_uop_valid 0 and no accept that cycle; EMPTY next cycle. The next instruction then gives seq 0.
- Throughput: 8 back-to-back ADDIs with rename always ready -> 8 uops on 8 consecutive cycles, no bubbles. Async reset pulse mid-stream -> o_uop_valid drops at once, o_ready 1.

Source files
------------

// File: rtl/decode_uop_sequencer.sv
// Decode-stage micro-op sequencer. It holds one aligned instruction, shows it
// to the combinational field decoder, and then sends it to rename. A normal
// instruction goes out as one uop. A complex instruction (AMO read-modify-write)
// is cracked into CRACK_UOPS uops. Both sides use valid/ready, and a flush
// drops the held instruction together with any crack still in progress.
module decode_uop_sequencer #(
    parameter int PC_WIDTH   = 64,
    parameter int CRACK_UOPS = 3,
    parameter int SEQ_WIDTH  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_flush,
    input  logic                 i_valid,
    input  logic [31:0]          i_instr,
    input  logic [PC_WIDTH-1:0]  i_pc,
    output logic                 o_ready,
    output logic [31:0]          o_dec_instr,
    input  logic                 i_dec_unknown,
    input  logic                 i_dec_complex,
    output logic                 o_uop_valid,
    input  logic                 i_uop_ready,
    output logic [31:0]          o_uop_instr,
    output logic [PC_WIDTH-1:0]  o_uop_pc,
    output logic [SEQ_WIDTH-1:0] o_uop_seq,
    output logic                 o_uop_last,
    output logic                 o_uop_illegal
);

    localparam logic [SEQ_WIDTH-1:0] SEQ_LAST = SEQ_WIDTH'(CRACK_UOPS - 1);

    // Only occupancy is stored. Whether the held instruction is SINGLE or
    // CRACK is worked out again every cycle from the decoder flags. The held
    // word does not change until the last uop leaves, so the class cannot
    // change partway through a crack.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                 state_p0;
    logic [SEQ_WIDTH-1:0]   seq_p0;
    logic [31:0]            instr_p0;
    logic [PC_WIDTH-1:0]    pc_p0;

    logic                   vld_p0;
    logic                   is_crack;
    logic                   uop_last;
    logic                   uop_fire;
    logic                   accept;

    assign vld_p0   = (state_p0 == ST_FULL);
    // An unknown instruction is never cracked, even when complex is also set.
    assign is_crack = vld_p0 & ~i_dec_unknown & i_dec_complex;
    assign uop_last = vld_p0 & (~is_crack | (seq_p0 == SEQ_LAST));

    assign o_uop_valid   = vld_p0 & ~i_flush;
    assign uop_fire      = o_uop_valid & i_uop_ready;
    // Taking a new instruction in the same cycle the last uop leaves keeps
    // simple instructions flowing at one per cycle.
    assign o_ready       = ~i_flush & (~vld_p0 | (uop_fire & uop_last));
    assign accept        = i_valid & o_ready;

    assign o_dec_instr   = instr_p0;
    assign o_uop_instr   = instr_p0;
    assign o_uop_pc      = pc_p0;
    assign o_uop_seq     = is_crack ? seq_p0 : '0;
    assign o_uop_last    = uop_last;
    assign o_uop_illegal = vld_p0 & i_dec_unknown;

    // ---- stage p0: held instruction, occupancy and crack index ----
    // Flush wins over every handshake. A load replaces an instruction whose
    // last uop leaves in the same cycle.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_p0 <= ST_EMPTY;
            seq_p0   <= '0;
            instr_p0 <= '0;
            pc_p0    <= '0;
        end else if (i_flush) begin
            state_p0 <= ST_EMPTY;
            seq_p0   <= '0;
        end else begin
            if (uop_fire) begin
                if (uop_last) begin
                    seq_p0 <= '0;
                end else begin
                    seq_p0 <= seq_p0 + SEQ_WIDTH'(1);
                end
            end
            if (accept) begin
                state_p0 <= ST_FULL;
                instr_p0 <= i_instr;
                pc_p0    <= i_pc;
            end else if (uop_fire && uop_last) begin
                state_p0 <= ST_EMPTY;
            end
        end
    end

endmodule
